// File: rtl/alu_uart_ctrl_if.sv
// Handshake bundle between the UART/ALU front-end controller and its surroundings.
// slave = the controller, master = the UART RX/TX and ALU side.
interface alu_uart_ctrl_if #(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6
);
  logic [NB_DATA-1:0] i_rx_data;
  logic               i_rx_done;
  logic               i_tx_done;
  logic [NB_DATA-1:0] i_alu_result;
  logic [NB_DATA-1:0] o_alu_data_A;
  logic [NB_DATA-1:0] o_alu_data_B;
  logic [NB_OP-1:0]   o_alu_op;
  logic [NB_DATA-1:0] o_tx_data;
  logic               o_tx_start;
  logic               o_busy;

  modport slave (
    input  i_rx_data, i_rx_done, i_tx_done, i_alu_result,
    output o_alu_data_A, o_alu_data_B, o_alu_op, o_tx_data, o_tx_start, o_busy
  );

  modport master (
    output i_rx_data, i_rx_done, i_tx_done, i_alu_result,
    input  o_alu_data_A, o_alu_data_B, o_alu_op, o_tx_data, o_tx_start, o_busy
  );
endinterface

// File: rtl/alu_uart_ctrl.sv
// Collects A, B and opcode bytes from UART RX, drives them to the ALU,
// then forwards the ALU result to UART TX with a start/done handshake.
module alu_uart_ctrl #(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6
) (
  input  logic          i_clk,
  input  logic          i_reset,
  alu_uart_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    WAIT_A  = 3'd0,
    WAIT_B  = 3'd1,
    WAIT_OP = 3'd2,
    EXEC    = 3'd3,
    WAIT_TX = 3'd4
  } state_t;

  state_t             state_q, state_n;
  logic [NB_DATA-1:0] a_q, a_n;
  logic [NB_DATA-1:0] b_q, b_n;
  logic [NB_OP-1:0]   op_q, op_n;
  logic [NB_DATA-1:0] tx_q, tx_n;
  logic               start_q, start_n;
  logic               busy_q, busy_n;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= WAIT_A;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      tx_q    <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      a_q     <= a_n;
      b_q     <= b_n;
      op_q    <= op_n;
      tx_q    <= tx_n;
      start_q <= start_n;
      busy_q  <= busy_n;
    end
  end

  always_comb begin
    state_n = state_q;
    a_n     = a_q;
    b_n     = b_q;
    op_n    = op_q;
    tx_n    = tx_q;
    start_n = 1'b0;
    case (state_q)
      WAIT_A: if (bus.i_rx_done) begin
        a_n     = bus.i_rx_data;
        state_n = WAIT_B;
      end
      WAIT_B: if (bus.i_rx_done) begin
        b_n     = bus.i_rx_data;
        state_n = WAIT_OP;
      end
      WAIT_OP: if (bus.i_rx_done) begin
        op_n    = bus.i_rx_data[NB_OP-1:0];
        state_n = EXEC;
      end
      // One cycle for the ALU to settle on the freshly registered operands.
      EXEC: begin
        tx_n    = bus.i_alu_result;
        start_n = 1'b1;
        state_n = WAIT_TX;
      end
      // A done strobe coincident with our own start pulse belongs to a previous byte.
      WAIT_TX: if (bus.i_tx_done && !start_q) state_n = WAIT_A;
      default: state_n = WAIT_A;
    endcase
    busy_n = (state_n == EXEC) || (state_n == WAIT_TX);
  end

  assign bus.o_alu_data_A = a_q;
  assign bus.o_alu_data_B = b_q;
  assign bus.o_alu_op     = op_q;
  assign bus.o_tx_data    = tx_q;
  assign bus.o_tx_start   = start_q;
  assign bus.o_busy       = busy_q;

endmodule

// File: tb/tb_alu_uart_ctrl.sv
// Scoreboard bench for alu_uart_ctrl: stimulus pushes expected TX bytes,
// a negedge monitor pops them whenever the controller raises o_tx_start.
module tb_alu_uart_ctrl;
  localparam int NB_DATA = 8;
  localparam int NB_OP   = 6;

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   passed = 0;
  int   total = 0;
  exp_t sb[$];
  logic prev_start = 1'b0;

  alu_uart_ctrl_if #(.NB_DATA(NB_DATA), .NB_OP(NB_OP)) bus ();

  alu_uart_ctrl #(.NB_DATA(NB_DATA), .NB_OP(NB_OP)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference ALU: the controller only forwards whatever this produces.
  always_comb begin
    case (bus.o_alu_op)
      6'h20:   bus.i_alu_result = bus.o_alu_data_A + bus.o_alu_data_B;
      6'h22:   bus.i_alu_result = bus.o_alu_data_A - bus.o_alu_data_B;
      6'h24:   bus.i_alu_result = bus.o_alu_data_A & bus.o_alu_data_B;
      6'h25:   bus.i_alu_result = bus.o_alu_data_A | bus.o_alu_data_B;
      6'h26:   bus.i_alu_result = bus.o_alu_data_A ^ bus.o_alu_data_B;
      6'h27:   bus.i_alu_result = ~(bus.o_alu_data_A | bus.o_alu_data_B);
      6'h03:   bus.i_alu_result = $signed(bus.o_alu_data_A) >>> bus.o_alu_data_B;
      6'h02:   bus.i_alu_result = bus.o_alu_data_A >> bus.o_alu_data_B;
      default: bus.i_alu_result = 8'hA1;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (!rst && bus.o_tx_start) begin
      chk("start_single_cycle", {31'd0, prev_start}, 32'd0);
      chk("busy_at_start", {31'd0, bus.o_busy}, 32'd1);
      if (sb.size() == 0) begin
        total++;
        $display("FAIL unexpected_start: got data %0h with empty scoreboard", bus.o_tx_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("tx_data", {24'd0, bus.o_tx_data}, {24'd0, e.data});
        chk("tx_latency", cyc, e.cyc);
      end
    end
    prev_start <= bus.o_tx_start;
  end

  task automatic send_byte(input logic [7:0] d);
    @(negedge clk);
    bus.i_rx_data = d;
    bus.i_rx_done = 1'b1;
    @(negedge clk);
    bus.i_rx_done = 1'b0;
  endtask

  task automatic send_op(input logic [7:0] d, input logic [7:0] exp);
    exp_t e;
    @(negedge clk);
    e.data = exp;
    e.cyc  = cyc + 2;
    sb.push_back(e);
    bus.i_rx_data = d;
    bus.i_rx_done = 1'b1;
    @(negedge clk);
    bus.i_rx_done = 1'b0;
  endtask

  task automatic wait_start();
    int n = 0;
    while (!bus.o_tx_start && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n == 20) begin
      total++;
      $display("FAIL start_timeout: o_tx_start never rose within 20 cycles");
    end
  endtask

  task automatic finish_tx();
    wait_start();
    @(negedge clk);
    bus.i_tx_done = 1'b1;
    @(negedge clk);
    bus.i_tx_done = 1'b0;
    chk("busy_after_done", {31'd0, bus.o_busy}, 32'd0);
  endtask

  task automatic txn(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                     input logic [7:0] exp);
    send_byte(a);
    send_byte(b);
    send_op(op, exp);
    finish_tx();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_A"},     {24'd0, bus.o_alu_data_A}, 32'd0);
    chk({tag, "_B"},     {24'd0, bus.o_alu_data_B}, 32'd0);
    chk({tag, "_op"},    {26'd0, bus.o_alu_op}, 32'd0);
    chk({tag, "_tx"},    {24'd0, bus.o_tx_data}, 32'd0);
    chk({tag, "_start"}, {31'd0, bus.o_tx_start}, 32'd0);
    chk({tag, "_busy"},  {31'd0, bus.o_busy}, 32'd0);
  endtask

  initial begin
    bus.i_rx_data = '0;
    bus.i_rx_done = 1'b0;
    bus.i_tx_done = 1'b0;
    #1;
    chk_zero("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // ADD, with operand/op register and hold checks
    txn(8'h05, 8'h03, 8'h20, 8'h08);
    chk("reg_A", {24'd0, bus.o_alu_data_A}, 32'h05);
    chk("reg_B", {24'd0, bus.o_alu_data_B}, 32'h03);
    chk("reg_op", {26'd0, bus.o_alu_op}, 32'h20);
    chk("tx_hold", {24'd0, bus.o_tx_data}, 32'h08);

    txn(8'h03, 8'h05, 8'h22, 8'hFE);   // SUB wraps
    txn(8'hF0, 8'h02, 8'h03, 8'hFC);   // SRA keeps sign
    txn(8'h0C, 8'h03, 8'hE5, 8'h0F);   // upper opcode bits stripped -> OR
    chk("op_truncated", {26'd0, bus.o_alu_op}, 32'h25);
    txn(8'h0C, 8'h03, 8'h3F, 8'hA1);   // unknown op passes through

    // Stray RX byte and early TX done while start is high are both ignored
    send_byte(8'h11);
    send_byte(8'h22);
    send_op(8'h26, 8'h33);
    wait_start();
    bus.i_rx_data = 8'h77;
    bus.i_rx_done = 1'b1;
    bus.i_tx_done = 1'b1;
    @(negedge clk);
    bus.i_rx_done = 1'b0;
    bus.i_tx_done = 1'b0;
    chk("drop_busy", {31'd0, bus.o_busy}, 32'd1);
    chk("drop_A", {24'd0, bus.o_alu_data_A}, 32'h11);
    chk("drop_B", {24'd0, bus.o_alu_data_B}, 32'h22);
    chk("drop_op", {26'd0, bus.o_alu_op}, 32'h26);
    chk("drop_tx", {24'd0, bus.o_tx_data}, 32'h33);
    @(negedge clk);
    chk("still_wait_tx", {31'd0, bus.o_busy}, 32'd1);
    bus.i_tx_done = 1'b1;
    @(negedge clk);
    bus.i_tx_done = 1'b0;
    chk("late_done_idle", {31'd0, bus.o_busy}, 32'd0);
    txn(8'h0A, 8'h0B, 8'h24, 8'h0A);   // fresh sequence after the drop
    chk("fresh_A", {24'd0, bus.o_alu_data_A}, 32'h0A);

    // Asynchronous reset mid-sequence, between clock edges
    send_byte(8'h55);
    send_byte(8'h66);
    #2;
    rst = 1'b1;
    #1;
    chk_zero("async_rst");
    @(negedge clk);
    rst = 1'b0;
    chk("rst_hold_A", {24'd0, bus.o_alu_data_A}, 32'd0);
    txn(8'h01, 8'h01, 8'h20, 8'h02);

    // Back-to-back transactions
    txn(8'hAA, 8'h55, 8'h26, 8'hFF);
    txn(8'h0F, 8'hF0, 8'h27, 8'h00);
    txn(8'h80, 8'h03, 8'h02, 8'h10);

    repeat (3) @(negedge clk);
    chk("sb_drained", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end
endmodule
